// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the multi-cycle serial add/subtract unit.
//   sa_state_t : controller states (IDLE / RUN / DONE)
//   sa_cnt_w   : width of a counter able to hold 0 .. steps-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   // $clog2(1) is 0, which would give a zero-width counter for STEPS=1.
   function automatic int unsigned sa_cnt_w(input int unsigned steps);
      if (steps <= 1) begin
         return 1;
      end
      return unsigned'($clog2(steps));
   endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//   Single-bit full adder, one slice of the serial adder's carry chain.
//   a, b : operand bits
//   cin  : carry in
//   y    : {cout, s}
// ---------------------------------------------------------------------------
module fa_cell (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   output logic [1:0] y
);

   assign y = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};

endmodule : fa_cell

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Multi-cycle add/subtract: takes two WIDTH-bit operands over a
//   valid/ready handshake, processes BITS_PER_CYCLE bits per clock through a
//   chain of full-adder cells, and presents {sum, cout, ovf} on a second
//   valid/ready handshake.
//
//   clk          : rising-edge clock
//   n_reset      : asynchronous active-low reset
//   start_valid  : a/b/sub valid          start_ready : operands accepted
//   a, b         : operands               sub         : 1 = a-b, 0 = a+b
//   busy         : state != IDLE
//   res_valid    : result valid           res_ready   : consumer takes result
//   sum          : result mod 2^WIDTH
//   cout         : carry out of MSB (for sub, 1 = no borrow)
//   ovf          : two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STEPS     = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW        = sa_cnt_w(STEPS);
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   if ((WIDTH < 2) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
   end

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    step_q, step_d;

   logic [BITS_PER_CYCLE:0]             c;
   logic [BITS_PER_CYCLE-1:0]           s;
   logic [WIDTH+BITS_PER_CYCLE-1:0]     acc_shift;

   // Carry chain across the slice: c[0] is the registered carry, c[N] the
   // slice carry-out, c[N-1] the carry into the top cell of the slice.
   assign c[0] = carry_q;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
      fa_cell u_fa (
         .a   (opa_q[i]),
         .b   (opb_q[i]),
         .cin (c[i]),
         .y   ({c[i+1], s[i]})
      );
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      step_d      = step_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      acc_shift   = {s, acc_q};

      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               state_d = RUN;
               opa_d   = a;
               // Subtraction as a + ~b + 1: invert b here, seed the carry.
               opb_d   = b ^ {WIDTH{sub}};
               carry_d = sub;
               step_d  = '0;
            end
         end
         RUN: begin
            opa_d   = opa_q >> BITS_PER_CYCLE;
            opb_d   = opb_q >> BITS_PER_CYCLE;
            acc_d   = acc_shift[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
            carry_d = c[BITS_PER_CYCLE];
            step_d  = step_q + CW'(1);
            if (step_q == LAST_STEP) begin
               state_d = DONE;
               // Partial sums build up in acc_q so the visible result only
               // changes on completion and is retained through IDLE/RUN.
               sum_d   = acc_d;
               cout_d  = c[BITS_PER_CYCLE];
               ovf_d   = c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic n_reset;

   // WIDTH=8, BITS_PER_CYCLE=1 instance
   logic       sv, sr, bsy, rv, rr, sb, co, ov;
   logic [7:0] a, b, sm;

   // WIDTH=8, BITS_PER_CYCLE=4 instance
   logic       sv4, sr4, bsy4, rv4, rr4, sb4, co4, ov4;
   logic [7:0] a4, b4, sm4;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int          lat;

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .n_reset(n_reset),
      .start_valid(sv), .start_ready(sr), .a(a), .b(b), .sub(sb),
      .busy(bsy), .res_valid(rv), .res_ready(rr),
      .sum(sm), .cout(co), .ovf(ov)
   );

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .n_reset(n_reset),
      .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4), .sub(sb4),
      .busy(bsy4), .res_valid(rv4), .res_ready(rr4),
      .sum(sm4), .cout(co4), .ovf(ov4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start an op on the 1-bit/cycle DUT and wait (bounded) for res_valid.
   task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s,
                         output int l);
      a  = x;
      b  = y;
      sb = s;
      sv = 1'b1;
      tick();
      sv = 1'b0;
      l  = 0;
      while (!rv && l < 40) begin
         tick();
         l++;
      end
   endtask

   task automatic release8;
      rr = 1'b1;
      tick();
      rr = 1'b0;
   endtask

   // Arithmetic reference: {sum, cout, ovf}
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
      logic [8:0] t;
      logic [7:0] r;
      logic       v;
      if (s) begin
         t = {1'b0, x} + {1'b0, ~y} + 9'd1;
         r = t[7:0];
         v = (x[7] != y[7]) && (r[7] != x[7]);
      end else begin
         t = {1'b0, x} + {1'b0, y};
         r = t[7:0];
         v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      return {r, t[8], v};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] xa, xb;
      logic       xs;

      n_reset = 1'b0;
      sv = 1'b0; rr = 1'b0; a = '0; b = '0; sb = 1'b0;
      sv4 = 1'b0; rr4 = 1'b0; a4 = '0; b4 = '0; sb4 = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_start_ready", sr, 1'b1);
      chk("rst_busy", bsy, 1'b0);
      chk("rst_res_valid", rv, 1'b0);
      chk("rst_sum", sm, 8'h00);
      chk("rst_cout", co, 1'b0);
      chk("rst_ovf", ov, 1'b0);
      n_reset = 1'b1;
      tick();
      chk("post_rst_start_ready", sr, 1'b1);
      chk("post_rst_busy", bsy, 1'b0);

      // 100 + 27
      start8(8'd100, 8'd27, 1'b0, lat);
      chk("t1_latency", lat, 8);
      chk("t1_sum", sm, 8'd127);
      chk("t1_cout", co, 1'b0);
      chk("t1_ovf", ov, 1'b0);
      chk("t1_start_ready_done", sr, 1'b0);
      release8();
      chk("t1_idle_res_valid", rv, 1'b0);
      chk("t1_idle_start_ready", sr, 1'b1);
      chk("t1_idle_sum_retained", sm, 8'd127);

      // 0xFF + 0x01
      start8(8'hFF, 8'h01, 1'b0, lat);
      chk("t2a_latency", lat, 8);
      chk("t2a_sum", sm, 8'h00);
      chk("t2a_cout", co, 1'b1);
      chk("t2a_ovf", ov, 1'b0);
      release8();

      // 0x7F + 0x01
      start8(8'h7F, 8'h01, 1'b0, lat);
      chk("t2b_sum", sm, 8'h80);
      chk("t2b_cout", co, 1'b0);
      chk("t2b_ovf", ov, 1'b1);
      release8();

      // 7 - 5
      start8(8'd7, 8'd5, 1'b1, lat);
      chk("t3a_sum", sm, 8'h02);
      chk("t3a_cout", co, 1'b1);
      chk("t3a_ovf", ov, 1'b0);
      release8();

      // 5 - 7
      start8(8'd5, 8'd7, 1'b1, lat);
      chk("t3b_sum", sm, 8'hFE);
      chk("t3b_cout", co, 1'b0);
      chk("t3b_ovf", ov, 1'b0);
      release8();

      // 0x80 - 0x01
      start8(8'h80, 8'h01, 1'b1, lat);
      chk("t3c_sum", sm, 8'h7F);
      chk("t3c_cout", co, 1'b1);
      chk("t3c_ovf", ov, 1'b1);
      release8();

      // Backpressure: 3 + 4 held in DONE with a new op offered
      start8(8'd3, 8'd4, 1'b0, lat);
      chk("t4_latency", lat, 8);
      a = 8'h11; b = 8'h22; sb = 1'b0; sv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_res_valid", rv, 1'b1);
         chk("t4_hold_sum", sm, 8'd7);
         chk("t4_hold_start_ready", sr, 1'b0);
      end
      rr = 1'b1;
      tick();
      rr = 1'b0;
      sv = 1'b0;
      chk("t4_release_busy", bsy, 1'b0);
      chk("t4_release_res_valid", rv, 1'b0);
      tick();
      chk("t4_no_accept_busy", bsy, 1'b0);
      chk("t4_sum_retained", sm, 8'd7);

      // Reset mid-RUN
      a = 8'h55; b = 8'h66; sb = 1'b0; sv = 1'b1;
      tick();
      sv = 1'b0;
      tick(); tick(); tick();
      chk("t5_busy_before", bsy, 1'b1);
      n_reset = 1'b0;
      #1;
      chk("t5_busy", bsy, 1'b0);
      chk("t5_res_valid", rv, 1'b0);
      chk("t5_start_ready", sr, 1'b1);
      tick();
      n_reset = 1'b1;
      tick();
      chk("t5_sum_cleared", sm, 8'h00);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t5_no_res_valid", rv, 1'b0);
      end
      start8(8'd9, 8'd9, 1'b0, lat);
      chk("t5_latency", lat, 8);
      chk("t5_sum", sm, 8'd18);
      chk("t5_cout", co, 1'b0);
      release8();

      // 4 bits/cycle: corners then random add/sub against the model
      for (int i = 0; i < 1000; i++) begin
         case (i)
            0: begin xa = 8'h00; xb = 8'h00; xs = 1'b0; end
            1: begin xa = 8'hFF; xb = 8'hFF; xs = 1'b0; end
            2: begin xa = 8'h80; xb = 8'h80; xs = 1'b0; end
            3: begin xa = 8'h7F; xb = 8'h80; xs = 1'b1; end
            4: begin xa = 8'h0F; xb = 8'h01; xs = 1'b0; end
            5: begin xa = 8'h00; xb = 8'h00; xs = 1'b1; end
            default: begin
               xa = 8'($urandom_range(0, 255));
               xb = 8'($urandom_range(0, 255));
               xs = 1'($urandom_range(0, 1));
            end
         endcase
         a4 = xa; b4 = xb; sb4 = xs; sv4 = 1'b1;
         tick();
         sv4 = 1'b0;
         lat = 0;
         while (!rv4 && lat < 20) begin
            tick();
            lat++;
         end
         chk("t6_latency", lat, 2);
         chk("t6_result", {sm4, co4, ov4}, model(xa, xb, xs));
         rr4 = 1'b1;
         tick();
         rr4 = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_adder
